// File: rtl/nn_axis_pkg.sv
// Shared definitions for the NN classifier AXI4-Stream blocks (MM2S loader
// and S2MM result streamer): beat geometry, FSM state encoding, pad value.
package nn_axis_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int LANE_W      = 16;
  localparam int LANES       = 4;

  // Lane value used for result slots past the end of a frame.
  localparam logic [LANE_W-1:0] LANE_PAD = 16'h0000;

  // Streamer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } nn_state_e;

endpackage

// File: rtl/axis_nn_result_streamer_if.sv
// AXI4-Stream bundle between the result streamer and the S2MM DMA channel.
interface axis_nn_result_streamer_if import nn_axis_pkg::*; ();

  logic [AXIS_DATA_W-1:0] tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/nn_lane_packer.sv
// Collects up to four 16-bit results into one 64-bit beat, first result in
// the most significant lane, unused lanes padded with zero. dout already
// includes the datum presented this cycle, so the beat can be registered on
// the same edge that absorbs the last read.
module nn_lane_packer import nn_axis_pkg::*; (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_en,
  input  logic                   clear,
  input  logic [LANE_W-1:0]      din,
  output logic [AXIS_DATA_W-1:0] dout
);

  logic [AXIS_DATA_W-1:0] shift_q, shift_d, shift_view;
  logic [2:0]             lane_q, lane_d, lane_view;

  // Present the beat as it stands once this cycle's datum is included,
  // left-aligned so word 0 of the beat sits in the top lane.
  always_comb begin
    shift_view = load_en ? {shift_q[AXIS_DATA_W-LANE_W-1:0], din} : shift_q;
    lane_view  = lane_q + {2'b00, load_en};
    case (lane_view)
      3'd1:    dout = {shift_view[LANE_W-1:0], LANE_PAD, LANE_PAD, LANE_PAD};
      3'd2:    dout = {shift_view[2*LANE_W-1:0], LANE_PAD, LANE_PAD};
      3'd3:    dout = {shift_view[3*LANE_W-1:0], LANE_PAD};
      3'd4:    dout = shift_view;
      default: dout = {LANE_PAD, LANE_PAD, LANE_PAD, LANE_PAD};
    endcase
    shift_d = clear ? '0 : shift_view;
    lane_d  = clear ? 3'd0 : lane_view;
  end

  // Shift register and lane count; clear wins so the next beat starts empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      lane_q  <= 3'd0;
    end else begin
      shift_q <= shift_d;
      lane_q  <= lane_d;
    end
  end

endmodule

// File: rtl/axis_nn_result_streamer.sv
// S2MM-side streamer: on start, reads N_WORDS results from the xout BRAM,
// packs four per beat and sends the beats out with tlast on the final one.
// One beat is fetched, captured and sent at a time; no overlap across beats.
module axis_nn_result_streamer import nn_axis_pkg::*; #(
  parameter int N_WORDS = 10,
  parameter int ADDR_W  = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  output logic                 ready,
  output logic                 done,
  output logic                 xout_enb,
  output logic [ADDR_W-1:0]    xout_addrb,
  input  logic [LANE_W-1:0]    xout_doutb,
  axis_nn_result_streamer_if.master m_axis
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_FETCH   = ST_FETCH;
  localparam logic [2:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [2:0] S_SEND    = ST_SEND;
  localparam logic [2:0] S_DONE    = ST_DONE;

  // Word counter must be able to hold N_WORDS itself (up to 16).
  localparam logic [4:0] LAST_W = 5'(N_WORDS);

  logic [2:0]             state_q, state_d;
  logic [4:0]             w_q, w_d;
  logic                   rd_valid_q;
  logic [AXIS_DATA_W-1:0] tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [AXIS_DATA_W-1:0] pk_dout;
  logic                   pk_clear;

  assign ready      = (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);
  assign xout_enb   = (state_q == S_FETCH);
  assign xout_addrb = xout_enb ? ADDR_W'(w_q) : '0;
  assign pk_clear   = (state_q == S_CAPTURE) || (state_q == S_IDLE);

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;

  nn_lane_packer u_packer (
    .clk     (aclk),
    .rst_n   (aresetn),
    .load_en (rd_valid_q),
    .clear   (pk_clear),
    .din     (xout_doutb),
    .dout    (pk_dout)
  );

  // Frame sequencing: fetch up to four words, capture the beat, hand it off.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          w_d     = 5'd0;
        end
      end
      S_FETCH: begin
        w_d = w_q + 5'd1;
        if ((w_q[1:0] == 2'd3) || (w_d == LAST_W)) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        tdata_d  = pk_dout;
        tvalid_d = 1'b1;
        tlast_d  = (w_q == LAST_W);
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (tvalid_q && m_axis.tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          state_d  = tlast_q ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, word counter, read-data-valid delay and AXIS output register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      w_q        <= 5'd0;
      rd_valid_q <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      rd_valid_q <= xout_enb;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
    end
  end

endmodule

// File: tb/tb_axis_nn_result_streamer.sv
// Bench for axis_nn_result_streamer: three instances (10, 4 and 16 words)
// behind small BRAM models; expected beats are built straight from the
// BRAM contents and compared with what is handed off on the stream.
module tb_axis_nn_result_streamer;

  localparam int NW0 = 10;
  localparam int NW1 = 4;
  localparam int NW2 = 16;

  logic clock = 1'b0;
  logic aresetn;

  logic [2:0]  startA, treadyA, tvA, tlA, rdyA, dnA, enA;
  logic [63:0] tdA [3];
  logic [3:0]  adA [3];
  logic [15:0] doutA [3];
  logic [15:0] mem [3][16];

  int compareCount = 0;
  int mismatchCount = 0;

  logic [63:0] gotData [$];
  logic        gotLast [$];
  int          doneCnt, badRd, rdCnt, stallRd, firstTv;
  bit          timedOut;

  always #5 clock = ~clock;

  axis_nn_result_streamer_if ax0 ();
  axis_nn_result_streamer_if ax1 ();
  axis_nn_result_streamer_if ax2 ();

  axis_nn_result_streamer #(.N_WORDS(NW0), .ADDR_W(4)) dut0 (
    .aclk(clock), .aresetn(aresetn), .start(startA[0]), .ready(rdyA[0]), .done(dnA[0]),
    .xout_enb(enA[0]), .xout_addrb(adA[0]), .xout_doutb(doutA[0]), .m_axis(ax0));
  axis_nn_result_streamer #(.N_WORDS(NW1), .ADDR_W(4)) dut1 (
    .aclk(clock), .aresetn(aresetn), .start(startA[1]), .ready(rdyA[1]), .done(dnA[1]),
    .xout_enb(enA[1]), .xout_addrb(adA[1]), .xout_doutb(doutA[1]), .m_axis(ax1));
  axis_nn_result_streamer #(.N_WORDS(NW2), .ADDR_W(4)) dut2 (
    .aclk(clock), .aresetn(aresetn), .start(startA[2]), .ready(rdyA[2]), .done(dnA[2]),
    .xout_enb(enA[2]), .xout_addrb(adA[2]), .xout_doutb(doutA[2]), .m_axis(ax2));

  assign tdA[0] = ax0.tdata;  assign tvA[0] = ax0.tvalid;  assign tlA[0] = ax0.tlast;
  assign tdA[1] = ax1.tdata;  assign tvA[1] = ax1.tvalid;  assign tlA[1] = ax1.tlast;
  assign tdA[2] = ax2.tdata;  assign tvA[2] = ax2.tvalid;  assign tlA[2] = ax2.tlast;
  assign ax0.tready = treadyA[0];
  assign ax1.tready = treadyA[1];
  assign ax2.tready = treadyA[2];

  // BRAM port B models: registered read, data valid one cycle after enable.
  always @(posedge clock) begin
    for (int g = 0; g < 3; g++) begin
      if (enA[g]) doutA[g] <= mem[g][adA[g]];
    end
  end

  function automatic int nwOf(input int g);
    return (g == 0) ? NW0 : ((g == 1) ? NW1 : NW2);
  endfunction

  // Beat b of a frame: words 4b..4b+3 MSB lane first, zero past the end.
  function automatic logic [63:0] expBeat(input int g, input int b);
    logic [63:0] v = '0;
    for (int j = 0; j < 4; j++) begin
      int idx = 4 * b + j;
      v = v << 16;
      if (idx < nwOf(g)) v[15:0] = mem[g][idx];
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Runs one frame on instance g, entered and left at posedge+1.
  // stallCyc: tready low for that many cycles on the first beat.
  // rePulse: extra start pulses while in FETCH and in SEND.
  // resetAt: sample index at which aresetn is dropped mid-cycle (0 = never).
  task automatic applyStimulus(input int g, input int stallCyc, input bit rePulse,
                               input bit randReady, input int resetAt);
    int          edges = 0;
    int          stallLeft = stallCyc;
    bit          prevTv = 1'b0;
    bit          prevRdy = 1'b1;
    logic [63:0] prevData = '0;
    bit          seenDone = 1'b0;
    bit          finished = 1'b0;
    gotData.delete();
    gotLast.delete();
    doneCnt = 0; badRd = 0; rdCnt = 0; stallRd = 0; firstTv = -1; timedOut = 1'b0;
    treadyA[g] = 1'b1;
    startA[g]  = 1'b1;
    while (!finished && edges < 400) begin
      @(posedge clock);
      #1;
      edges++;
      startA[g] = rePulse && (edges == 2 || edges == 6);
      if (edges == resetAt) begin
        #3 aresetn = 1'b0;
        #1;
        checkOutput("rstTvalid", 64'(tvA[g]), 64'd0);
        checkOutput("rstTlast", 64'(tlA[g]), 64'd0);
        checkOutput("rstTdata", tdA[g], 64'd0);
        checkOutput("rstEnb", 64'(enA[g]), 64'd0);
        checkOutput("rstAddr", 64'(adA[g]), 64'd0);
        checkOutput("rstReady", 64'(rdyA[g]), 64'd1);
        checkOutput("rstDone", 64'(dnA[g]), 64'd0);
        #3 aresetn = 1'b1;
        finished = 1'b1;
      end else begin
        if (enA[g]) begin
          rdCnt++;
          if (int'(adA[g]) >= nwOf(g)) badRd++;
          if (tvA[g]) stallRd++;
        end
        if (tvA[g] && firstTv < 0) firstTv = edges;
        if (prevTv && !prevRdy) begin
          checkOutput("holdValid", 64'(tvA[g]), 64'd1);
          checkOutput("holdData", tdA[g], prevData);
        end
        if (seenDone) begin
          checkOutput("readyAfterDone", 64'(rdyA[g]), 64'd1);
          finished = 1'b1;
        end
        if (dnA[g]) begin
          doneCnt++;
          seenDone = 1'b1;
        end
        if (tvA[g] && stallLeft > 0) begin
          treadyA[g] = 1'b0;
          stallLeft--;
          checkOutput("stallData", tdA[g], expBeat(g, 0));
        end else begin
          treadyA[g] = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (tvA[g] && treadyA[g]) begin
          gotData.push_back(tdA[g]);
          gotLast.push_back(tlA[g]);
        end
        prevTv   = tvA[g];
        prevRdy  = treadyA[g];
        prevData = tdA[g];
      end
    end
    if (!finished) timedOut = 1'b1;
    startA[g]  = 1'b0;
    treadyA[g] = 1'b1;
  endtask

  // Compares the captured frame against the beats built from BRAM contents.
  task automatic checkFrame(input int g, input string name);
    int nb = (nwOf(g) + 3) / 4;
    checkOutput({name, ".timeout"}, 64'(timedOut), 64'd0);
    checkOutput({name, ".beats"}, 64'(gotData.size()), 64'(nb));
    for (int b = 0; b < nb; b++) begin
      if (b < gotData.size()) begin
        checkOutput({name, ".data"}, gotData[b], expBeat(g, b));
        checkOutput({name, ".last"}, 64'(gotLast[b]), 64'(b == nb - 1));
      end
    end
    checkOutput({name, ".done"}, 64'(doneCnt), 64'd1);
    checkOutput({name, ".badAddr"}, 64'(badRd), 64'd0);
    checkOutput({name, ".reads"}, 64'(rdCnt), 64'(nwOf(g)));
    checkOutput({name, ".stallReads"}, 64'(stallRd), 64'd0);
  endtask

  initial begin
    aresetn = 1'b0;
    startA  = '0;
    treadyA = '1;
    for (int j = 0; j < 16; j++) begin
      mem[0][j] = 16'(j + 1);
      mem[1][j] = 16'(j + 1);
      mem[2][j] = 16'($urandom);
    end
    repeat (3) @(posedge clock);
    #1;
    for (int g = 0; g < 3; g++) begin
      checkOutput("resetReady", 64'(rdyA[g]), 64'd1);
      checkOutput("resetDone", 64'(dnA[g]), 64'd0);
      checkOutput("resetEnb", 64'(enA[g]), 64'd0);
      checkOutput("resetAddr", 64'(adA[g]), 64'd0);
      checkOutput("resetTdata", tdA[g], 64'd0);
      checkOutput("resetTvalid", 64'(tvA[g]), 64'd0);
      checkOutput("resetTlast", 64'(tlA[g]), 64'd0);
    end
    @(negedge clock);
    aresetn = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] 10-word frame, tready high");
    applyStimulus(0, 0, 1'b0, 1'b0, 0);
    checkFrame(0, "plain10");
    checkOutput("latency10", 64'(firstTv), 64'd6);

    $display("[TB] 10-word frame, 5-cycle stall on first beat");
    applyStimulus(0, 5, 1'b0, 1'b0, 0);
    checkFrame(0, "stall10");

    $display("[TB] 4-word frame");
    applyStimulus(1, 0, 1'b0, 1'b0, 0);
    checkFrame(1, "plain4");
    checkOutput("latency4", 64'(firstTv), 64'd6);

    $display("[TB] start re-pulsed during FETCH and SEND, then replay");
    applyStimulus(0, 0, 1'b1, 1'b0, 0);
    checkFrame(0, "repulse10");
    applyStimulus(0, 0, 1'b0, 1'b0, 0);
    checkFrame(0, "replay10");

    $display("[TB] reset during second beat, then full frame");
    applyStimulus(0, 0, 1'b0, 1'b0, 9);
    checkOutput("abortBeats", 64'(gotData.size()), 64'd1);
    if (gotLast.size() > 0) checkOutput("abortLast", 64'(gotLast[0]), 64'd0);
    @(posedge clock);
    #1;
    applyStimulus(0, 0, 1'b0, 1'b0, 0);
    checkFrame(0, "afterReset10");

    $display("[TB] 16-word frames, random data and random tready");
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 16; j++) mem[2][j] = 16'($urandom);
      applyStimulus(2, 0, 1'b0, f[0], 0);
      checkFrame(2, "rand16");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/axis_nn_result_streamer.md
# axis_nn_result_streamer

Transmit-side AXI4-Stream master for the NN classifier. On a `start` pulse it reads `N_WORDS` 16-bit results from the classifier output BRAM (port B). It packs four results per 64-bit beat, first result in the most significant lane, and streams the beats out with `tlast` on the final beat. It sits between the xout BRAM and the S2MM DMA channel. It is the output counterpart to the MM2S-side loader that fills the xij/wb BRAMs.

## Interface
Parameters:
- `N_WORDS`, default 10: number of 16-bit results per frame. Legal range 1..16.
- `ADDR_W`, default 4: width of the BRAM address.

Ports:
- `aclk` in 1: the single clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle frame request, normally driven by `nn_classification_done`.
- `ready` out 1: high while IDLE. Reset value 1.
- `done` out 1: one-cycle pulse after the handshake of the last beat. Reset value 0.
- `xout_enb` out 1: BRAM read enable. Reset value 0.
- `xout_addrb` out `ADDR_W`: BRAM read address. Reset value 0.
- `xout_doutb` in 16: BRAM read data, valid exactly 1 cycle after an enabled address.
- `m_axis_tdata` out 64: beat data. Reset value 0.
- `m_axis_tvalid` out 1: beat valid. Reset value 0.
- `m_axis_tlast` out 1: final beat marker. Reset value 0.
- `m_axis_tready` in 1: downstream ready.

## Operation
- States are IDLE, FETCH, CAPTURE, SEND and DONE.
- IDLE:
  - `ready` is 1.
  - `start` high → FETCH. Word index `w` = 0 and lane index `l` = 0.
  - `start` is ignored in every other state.
- FETCH:
  - Each cycle, drive `xout_enb`=1 and `xout_addrb`=`w`, then `w`++.
  - Stay in FETCH for 4 cycles, or fewer if `w` reaches `N_WORDS`.
  - Returned `xout_doutb` is shifted into the pack register one cycle later.
  - Lane order: word 4k+0 → [63:48], 4k+1 → [47:32], 4k+2 → [31:16], 4k+3 → [15:0].
  - After the last read → CAPTURE.
- CAPTURE:
  - One cycle to absorb the final read datum.
  - Lanes not filled are forced to 16'h0000.
  - Load the output register: `tvalid`=1, and `tlast`=1 when `w` == `N_WORDS`.
  - → SEND.
- SEND:
  - Hold `tdata`, `tvalid` and `tlast` stable until `tvalid && tready`.
  - On the handshake, clear `tvalid` and `tlast`.
  - If this was the last beat → DONE, otherwise → FETCH.
- DONE: pulse `done` for one cycle → IDLE.
- `xout_enb` is 0 outside FETCH. No BRAM read is issued for an address ≥ `N_WORDS`.
- Beat count per frame is ceil(`N_WORDS`/4).
- Reset asserted in any state returns the block to IDLE with the reset values above. The partial frame is discarded and no `tlast` is emitted.

## Timing
- `start` is sampled at edge E0.
  - Address 0 is driven during cycle E0–E1, and addresses 1..3 during the next three cycles.
  - CAPTURE occupies E4–E5.
  - `tvalid` rises after E5, which is 6 edges after `start`.
- A full beat takes 6 cycles with `tready` held at 1. A partial beat of m words takes m+2 cycles.
- Steady-state throughput is 1 beat per 6 cycles. This needs no pipelining across beats.
- `tdata` must not change while `tvalid`=1 and `tready`=0.
- `done` rises 1 cycle after the handshake of the last beat. `ready` returns 1 on the following cycle.
- If `tready` is held low, the block stalls indefinitely in SEND. No timeout.

## Structure
- Shared package `nn_axis_pkg` holds:
  - `AXIS_DATA_W`=64, `LANE_W`=16 and `LANES`=4.
  - The state enum.
  - The padding constant 16'h0000.
  - The package is shared with the MM2S loader.
- One natural sub-module, `nn_lane_packer`. It owns the shift register, the lane counter and the zero-pad logic, and takes `load_en`, `clear` and `din[15:0]` and returns `dout[63:0]`.
- The FSM, the address counter and the AXIS output register stay in the top module.

## Test plan
- `N_WORDS`=10, BRAM holding 16'h0001..16'h000A, `tready`=1:
  - Expect beats 64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008 and 64'h0009_000A_0000_0000.
  - `tlast` only on the 3rd beat.
  - One `done` pulse.
  - Addresses 10..15 are never read.
- Backpressure: `tready`=0 for 5 cycles after the first `tvalid`.
  - `tdata` stays stable at 64'h0001_0002_0003_0004.
  - No BRAM reads during the stall.
  - After release, the sequence is identical to the first scenario.
- `N_WORDS`=4: a single beat 64'h0001_0002_0003_0004 with `tlast`=1. `tvalid` appears 6 cycles after `start`.
- `start` re-pulsed during FETCH and during SEND:
  - Ignored; still exactly 3 beats and 1 `done`.
  - A fresh `start` in IDLE replays the frame.
- `aresetn` dropped mid-second-beat:
  - Outputs take reset values immediately (asynchronous).
  - `ready`=1 after release.
  - The next `start` produces a full, correct 3-beat frame.
- `N_WORDS`=16 with random data: 4 beats. Every lane matches the BRAM contents in MSB-first order.
